// File: rtl/operand_sequencer_pkg.sv
// Shared types and constants for the operand sequencer.
// State encoding, opcode and operand-select values.
package operand_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LOAD = 4'd2;
  localparam logic [3:0] OP_MOVA = 4'd3;

  localparam logic [1:0] SEL_ACC  = 2'd0;
  localparam logic [1:0] SEL_REG  = 2'd1;
  localparam logic [1:0] SEL_SEXT = 2'd2;
  localparam logic [1:0] SEL_MEM  = 2'd3;

  // Unsupported opcodes fall back to the accumulator path.
  function automatic logic [1:0] sel_of(input logic [3:0] op);
    logic [1:0] s;
    case (op)
      OP_ADD:  s = SEL_REG;
      OP_ADDI: s = SEL_SEXT;
      OP_LOAD: s = SEL_MEM;
      OP_MOVA: s = SEL_ACC;
      default: s = SEL_ACC;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/operand_sequencer.sv
// Multi-cycle control FSM sequencing fetch, decode, execute,
// memory wait and write-back for the operand datapath.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Opcode,
  input  logic       Stall,
  output logic [1:0] Selector,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       ACCWrite,
  output logic       MemRead,
  output logic       Busy,
  output logic       Done,
  output logic       Illegal
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic       ill_q, ill_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          op_d    = Opcode;
          ill_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (!Stall) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!Stall) begin
          case (op_q)
            OP_ADD, OP_ADDI, OP_MOVA: state_d = S_EXEC;
            OP_LOAD: begin
              state_d = S_MEM;
              cnt_d   = CNT_INIT;
            end
            default: begin
              state_d = S_WB;
              ill_d   = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (!Stall) state_d = S_WB;
      end
      S_MEM: begin
        if (!Stall) begin
          if (cnt_q == 4'd0) state_d = S_WB;
          else cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        if (!Stall) begin
          state_d = S_IDLE;
          ill_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

  // Enables are gated by Stall; select and MemRead follow state only.
  always_comb begin
    Selector = SEL_ACC;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ACCWrite = 1'b0;
    MemRead  = 1'b0;
    Done     = 1'b0;
    Illegal  = 1'b0;
    Busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        IRWrite = !Stall;
        PCWrite = !Stall;
      end
      S_DECODE, S_EXEC: Selector = sel_of(op_q);
      S_MEM: begin
        Selector = sel_of(op_q);
        MemRead  = 1'b1;
      end
      S_WB: begin
        Selector = sel_of(op_q);
        ACCWrite = !Stall && !ill_q;
        Done     = !Stall;
        Illegal  = !Stall && ill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed cycle table, latency
// probes and randomized traffic against a step-queue model.
module tb_operand_sequencer;

  localparam int LAT = 3;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic       Stall = 1'b0;
  logic [1:0] Selector;
  logic       IRWrite, PCWrite, ACCWrite, MemRead;
  logic       Busy, Done, Illegal;

  int checks = 0;
  int errors = 0;

  operand_sequencer #(.MEM_LATENCY(LAT)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .Opcode(Opcode), .Stall(Stall),
    .Selector(Selector), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .ACCWrite(ACCWrite),
    .MemRead(MemRead), .Busy(Busy), .Done(Done),
    .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic       stall;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [8:0] outs();
    return {Selector, IRWrite, PCWrite, ACCWrite,
            MemRead, Busy, Done, Illegal};
  endfunction

  task automatic check(string name, logic [8:0] got,
                       logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (sel,ir,pc,acc,mr,busy,done,ill)",
               name, got, exp);
    end
  endtask

  task automatic add(bit r, bit s, int op, bit st, int sel,
                     bit ir, bit pc, bit acc, bit mr,
                     bit bz, bit dn, bit il);
    vec_t v;
    v.rst = r; v.start = s; v.op = 4'(op); v.stall = st;
    v.exp = {2'(sel), ir, pc, acc, mr, bz, dn, il};
    tbl.push_back(v);
  endtask

  // Model: an accepted instruction becomes a queue of steps;
  // each unstalled cycle retires the head step.
  localparam int K_F = 1, K_D = 2, K_E = 3, K_M = 4, K_W = 5;
  int         mq[$];
  logic [3:0] mop;

  function automatic logic [1:0] msel(logic [3:0] op);
    case (op)
      4'd0: return 2'd1;
      4'd1: return 2'd2;
      4'd2: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [8:0] mexp(logic st);
    logic legal;
    logic [1:0] s;
    legal = (mop < 4);
    s = msel(mop);
    if (mq.size() == 0) return 9'd0;
    case (mq[0])
      K_F: return {2'd0, !st, !st, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      K_D, K_E: return {s, 5'b00001, 2'b00};
      K_M: return {2'd3, 5'b00011, 2'b00};
      default: return {s, 1'b0, 1'b0, legal && !st, 1'b0,
                       1'b1, !st, !legal && !st};
    endcase
  endfunction

  task automatic madvance(logic r, logic s, logic [3:0] op,
                          logic st);
    if (r) mq.delete();
    else if (mq.size() == 0) begin
      if (s) begin
        mop = op;
        mq.push_back(K_F);
        mq.push_back(K_D);
        if (op == 4'd2)
          for (int i = 0; i < LAT; i++) mq.push_back(K_M);
        else if (op < 4) mq.push_back(K_E);
        mq.push_back(K_W);
      end
    end else if (!st) void'(mq.pop_front());
  endtask

  task automatic measure(logic [3:0] op, int exp_lat);
    int lat;
    bit found;
    lat = 0;
    found = 0;
    Start = 1'b1; Opcode = op; Stall = 1'b0;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      @(negedge CLK);
      if (Done) begin
        found = 1;
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    checks++;
    if (!found || lat != exp_lat) begin
      errors++;
      $display("FAIL latency op=%0d got=%0d found=%0d exp=%0d",
               op, lat, found, exp_lat);
    end
  endtask

  initial begin
    // ADD, with a Start pulse during EXEC that must be ignored
    add(0,1,0,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,1,1,0,0,1,0,0);
    add(0,0,0,0, 1,0,0,0,0,1,0,0);
    add(0,1,2,0, 1,0,0,0,0,1,0,0);
    add(0,0,0,0, 1,0,0,1,0,1,1,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);
    // illegal opcode 9
    add(0,1,9,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,1,1,0,0,1,0,0);
    add(0,0,0,0, 0,0,0,0,0,1,0,0);
    add(0,0,0,0, 0,0,0,0,0,1,1,1);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);
    // LOAD, three MEM cycles
    add(0,1,2,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,1,1,0,0,1,0,0);
    add(0,0,0,0, 3,0,0,0,0,1,0,0);
    add(0,0,0,0, 3,0,0,0,1,1,0,0);
    add(0,0,0,0, 3,0,0,0,1,1,0,0);
    add(0,0,0,0, 3,0,0,0,1,1,0,0);
    add(0,0,0,0, 3,0,0,1,0,1,1,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);
    // LOAD stalled two cycles mid-MEM
    add(0,1,2,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,1,1,0,0,1,0,0);
    add(0,0,0,0, 3,0,0,0,0,1,0,0);
    add(0,0,0,0, 3,0,0,0,1,1,0,0);
    add(0,0,0,1, 3,0,0,0,1,1,0,0);
    add(0,0,0,1, 3,0,0,0,1,1,0,0);
    add(0,0,0,0, 3,0,0,0,1,1,0,0);
    add(0,0,0,0, 3,0,0,0,1,1,0,0);
    add(0,0,0,0, 3,0,0,1,0,1,1,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);
    // ADDI stalled in FETCH and in WB
    add(0,1,1,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,1, 0,0,0,0,0,1,0,0);
    add(0,0,0,0, 0,1,1,0,0,1,0,0);
    add(0,0,0,0, 2,0,0,0,0,1,0,0);
    add(0,0,0,0, 2,0,0,0,0,1,0,0);
    add(0,0,0,1, 2,0,0,0,0,1,0,0);
    add(0,0,0,0, 2,0,0,1,0,1,1,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);
    // LOAD aborted by Reset in MEM cycle 2
    add(0,1,2,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,1,1,0,0,1,0,0);
    add(0,0,0,0, 3,0,0,0,0,1,0,0);
    add(0,0,0,0, 3,0,0,0,1,1,0,0);
    add(1,1,5,1, 3,0,0,0,1,1,0,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);
    // MOVA, Stall in IDLE has no effect
    add(0,1,3,1, 0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,1,1,0,0,1,0,0);
    add(0,0,0,0, 0,0,0,0,0,1,0,0);
    add(0,0,0,0, 0,0,0,0,0,1,0,0);
    add(0,0,0,0, 0,0,0,1,0,1,1,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset", outs(), 9'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;

    foreach (tbl[i]) begin
      Reset = tbl[i].rst; Start = tbl[i].start;
      Opcode = tbl[i].op; Stall = tbl[i].stall;
      @(negedge CLK);
      check($sformatf("row%0d", i), outs(), tbl[i].exp);
      @(posedge CLK); #1;
    end
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0;

    measure(4'd0, 4);
    measure(4'd1, 4);
    measure(4'd3, 4);
    measure(4'd2, 3 + LAT);
    measure(4'd12, 3);

    mq.delete();
    mop = 4'd0;
    for (int c = 0; c < 2000; c++) begin
      Reset = (c == 0) || ($urandom_range(0, 49) == 0);
      Start = $urandom_range(0, 1) != 0;
      Opcode = ($urandom_range(0, 3) != 0) ?
               4'($urandom_range(0, 3)) :
               4'($urandom_range(4, 15));
      Stall = $urandom_range(0, 3) == 0;
      @(negedge CLK);
      if (c > 0) check($sformatf("rand%0d", c), outs(), mexp(Stall));
      madvance(Reset, Start, Opcode, Stall);
      @(posedge CLK); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
